// File: rtl/rm_token_chain.sv
// Fixed-depth token pipeline: shifts tokens toward a retire port, supports per-stage clear and stall.
// Optional same-cycle pass-through on an empty chain when RM_TOKEN_CHAIN_BYPASS_EN is defined.
module rm_token_chain #(
    parameter int NUM_STAGES = 4,
    parameter int TOKEN_W    = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 token_valid_i,
    input  logic [TOKEN_W-1:0]                   token_i,
    output logic                                 token_ready_o,
    input  logic                                 stall_i,
    input  logic [NUM_STAGES-1:0]                clear_stage_i,
    output logic [NUM_STAGES-1:0]                stage_valid_o,
    output logic [NUM_STAGES*TOKEN_W-1:0]        stage_token_o,
    output logic                                 retire_valid_o,
    output logic [TOKEN_W-1:0]                   retire_token_o,
    input  logic                                 retire_ready_i,
    output logic [$clog2(NUM_STAGES+1)-1:0]      occupancy_o,
    output logic [15:0]                          drop_cnt_o
);

    localparam int OCC_W = $clog2(NUM_STAGES + 1);
    localparam int TOT_W = NUM_STAGES * TOKEN_W;

    logic [NUM_STAGES-1:0] r_valid;
    logic [TOT_W-1:0]      r_token;
    logic [15:0]           r_drop_cnt;

    logic [NUM_STAGES-1:0] w_live;
    logic                  w_advance;
    logic                  w_bypass;
    logic                  w_stage0_valid;
    logic [16:0]           w_drop_sum;

    // A stage being cleared this cycle is treated as empty everywhere downstream.
    assign w_live    = r_valid & ~clear_stage_i;
    assign w_advance = ~stall_i & (~w_live[NUM_STAGES-1] | retire_ready_i);

`ifdef RM_TOKEN_CHAIN_BYPASS_EN
    assign w_bypass = ~rst_i & ~(|r_valid) & ~stall_i & token_valid_i & retire_ready_i;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_stage0_valid = token_valid_i & ~w_bypass;
    assign w_drop_sum     = {1'b0, r_drop_cnt} + 17'($countones(r_valid & clear_stage_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid    <= '0;
            // NOTE: token storage is reset too so invalid slots never read back as X.
            r_token    <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            if (w_advance) begin
                r_valid <= {w_live[NUM_STAGES-2:0], w_stage0_valid};
                r_token <= {r_token[TOT_W-TOKEN_W-1:0], token_i};
            end else begin
                r_valid <= w_live;
            end
        end
    end

    assign token_ready_o  = w_advance & ~rst_i;
    assign retire_valid_o = w_live[NUM_STAGES-1] | w_bypass;
    assign retire_token_o = w_bypass ? token_i : r_token[TOT_W-1 -: TOKEN_W];
    assign stage_valid_o  = r_valid;
    assign stage_token_o  = r_token;
    assign occupancy_o    = OCC_W'($countones(r_valid));
    assign drop_cnt_o     = r_drop_cnt;

endmodule

// File: tb/tb_rm_token_chain.sv
// Directed bench for rm_token_chain with a per-stage array model checked every cycle.
// Honors RM_TOKEN_CHAIN_BYPASS_EN the same way the design does.
module tb_rm_token_chain;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             token_valid_i;
    logic [W-1:0]     token_i;
    logic             token_ready_o;
    logic             stall_i;
    logic [N-1:0]     clear_stage_i;
    logic [N-1:0]     stage_valid_o;
    logic [N*W-1:0]   stage_token_o;
    logic             retire_valid_o;
    logic [W-1:0]     retire_token_o;
    logic             retire_ready_i;
    logic [2:0]       occupancy_o;
    logic [15:0]      drop_cnt_o;

    always #5 clk_i = ~clk_i;

    rm_token_chain #(.NUM_STAGES(N), .TOKEN_W(W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .token_valid_i  (token_valid_i),
        .token_i        (token_i),
        .token_ready_o  (token_ready_o),
        .stall_i        (stall_i),
        .clear_stage_i  (clear_stage_i),
        .stage_valid_o  (stage_valid_o),
        .stage_token_o  (stage_token_o),
        .retire_valid_o (retire_valid_o),
        .retire_token_o (retire_token_o),
        .retire_ready_i (retire_ready_i),
        .occupancy_o    (occupancy_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one slot per stage, updated from the shift/hold/clear rules.
    logic         m_v [N];
    logic [W-1:0] m_t [N];
    int           m_drop;
    bit           m_on = 1'b0;

    function automatic bit m_empty();
        for (int k = 0; k < N; k++) if (m_v[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_bypass();
`ifdef RM_TOKEN_CHAIN_BYPASS_EN
        return m_empty() && !stall_i && token_valid_i && retire_ready_i && !rst_i;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_tail_live();
        return m_v[N-1] && !clear_stage_i[N-1];
    endfunction

    function automatic bit m_advance();
        return !stall_i && (!m_tail_live() || retire_ready_i);
    endfunction

    always @(posedge clk_i) begin
        int d;
        if (rst_i) begin
            for (int k = 0; k < N; k++) begin
                m_v[k] <= 1'b0;
                m_t[k] <= '0;
            end
            m_drop <= 0;
            m_on   <= 1'b1;
        end else if (m_on) begin
            d = 0;
            for (int k = 0; k < N; k++) if (m_v[k] && clear_stage_i[k]) d++;
            m_drop <= (m_drop + d > 65535) ? 65535 : m_drop + d;
            if (m_advance()) begin
                for (int k = 1; k < N; k++) begin
                    m_v[k] <= m_v[k-1] && !clear_stage_i[k-1];
                    m_t[k] <= m_t[k-1];
                end
                m_v[0] <= token_valid_i && !m_bypass();
                m_t[0] <= token_i;
            end else begin
                for (int k = 0; k < N; k++) m_v[k] <= m_v[k] && !clear_stage_i[k];
            end
        end
    end

    always @(negedge clk_i) begin
        logic [N-1:0] ev;
        int           occ;
        bit           bp;
        bit           rv;
        if (m_on) begin
            occ = 0;
            for (int k = 0; k < N; k++) begin
                ev[k] = m_v[k];
                occ += int'(m_v[k]);
            end
            bp = m_bypass();
            rv = m_tail_live() || bp;
            check("model_stage_valid", stage_valid_o, ev);
            check("model_occupancy", occupancy_o, occ);
            check("model_drop_cnt", drop_cnt_o, m_drop);
            check("model_token_ready", token_ready_o, m_advance() && !rst_i);
            check("model_retire_valid", retire_valid_o, rv);
            if (rv) check("model_retire_token", retire_token_o, bp ? token_i : m_t[N-1]);
            for (int k = 0; k < N; k++)
                if (m_v[k]) check("model_stage_token", stage_token_o[k*W +: W], m_t[k]);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        token_valid_i  = 1'b0;
        token_i        = '0;
        stall_i        = 1'b0;
        clear_stage_i  = '0;
        retire_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic fill_1_to_4();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            token_valid_i = 1'b1;
            token_i       = W'(c + 1);
            tick();
        end
        token_valid_i = 1'b0;
        token_i       = '0;
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        tick();
        #2;
        check("reset_valid", stage_valid_o, 0);
        check("reset_tokens", stage_token_o, 0);
        check("reset_ready", token_ready_o, 0);
        tick();

        // Single token latency.
        do_reset();
        for (int c = 0; c < 7; c++) begin
            token_valid_i  = (c == 0);
            token_i        = (c == 0) ? 32'hA5 : 32'h0;
            retire_ready_i = 1'b1;
            #2;
`ifdef RM_TOKEN_CHAIN_BYPASS_EN
            check("lat_rv", retire_valid_o, c == 0);
            if (c == 0) check("lat_tok", retire_token_o, 32'hA5);
            check("lat_occ", occupancy_o, 0);
`else
            check("lat_rv", retire_valid_o, c == 4);
            if (c == 4) check("lat_tok", retire_token_o, 32'hA5);
            check("lat_occ", occupancy_o, (c >= 1 && c <= 4) ? 1 : 0);
`endif
            tick();
        end

        // Full chain back-pressure then drain.
        fill_1_to_4();
        #2;
        check("full_valid", stage_valid_o, 4'b1111);
        check("full_occ", occupancy_o, 4);
        check("full_ready", token_ready_o, 0);
        tick();
        for (int c = 5; c < 9; c++) begin
            retire_ready_i = 1'b1;
            #2;
            check("drain_rv", retire_valid_o, 1);
            check("drain_tok", retire_token_o, c - 4);
            tick();
        end

        // Clear of stage 2 in a full chain.
        fill_1_to_4();
        clear_stage_i = 4'b0100;
        #2;
        check("clr_drop_before", drop_cnt_o, 0);
        tick();
        clear_stage_i  = '0;
        retire_ready_i = 1'b1;
        for (int c = 5; c < 9; c++) begin
            #2;
            if (c == 5) begin
                check("clr_drop_after", drop_cnt_o, 1);
                check("clr_occ", occupancy_o, 3);
            end
            check("clr_rv", retire_valid_o, c != 6);
            if (c == 5) check("clr_tok", retire_token_o, 1);
            if (c == 7) check("clr_tok", retire_token_o, 3);
            if (c == 8) check("clr_tok", retire_token_o, 4);
            tick();
        end

        // Three stall cycles delay retirement by three.
        do_reset();
        token_valid_i = 1'b1;
        token_i       = 32'h77;
        tick();
        idle_inputs();
        retire_ready_i = 1'b1;
        tick();
        for (int c = 2; c < 9; c++) begin
            stall_i = (c >= 2 && c <= 4);
            #2;
            if (stall_i) begin
                check("stall_tokens", stage_token_o, 128'h0000_0000_0000_0000_0000_0077_0000_0000);
                check("stall_valid", stage_valid_o, 4'b0010);
                check("stall_ready", token_ready_o, 0);
            end else begin
                check("stall_rv", retire_valid_o, c == 7);
            end
            tick();
        end

        // Clear of the tail beats a ready retire.
        do_reset();
        token_valid_i = 1'b1;
        token_i       = 32'h55;
        tick();
        idle_inputs();
        retire_ready_i = 1'b1;
        for (int c = 1; c < 4; c++) tick();
        clear_stage_i = 4'b1000;
        #2;
        check("tailclr_rv", retire_valid_o, 0);
        tick();
        clear_stage_i = '0;
        #2;
        check("tailclr_drop", drop_cnt_o, 1);
        check("tailclr_occ", occupancy_o, 0);
        tick();

        // Reset with tokens in flight overrides everything.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            token_valid_i = 1'b1;
            token_i       = W'(c + 1);
            clear_stage_i = (c == 1) ? 4'b0001 : 4'b0000;
            tick();
        end
        idle_inputs();
        #2;
        check("rst_pre_drop", drop_cnt_o, 1);
        check("rst_pre_occ", occupancy_o, 3);
        rst_i         = 1'b1;
        token_valid_i = 1'b1;
        token_i       = 32'h9;
        clear_stage_i = 4'b0010;
        #1;
        check("rst_ready", token_ready_o, 0);
        tick();
        idle_inputs();
        rst_i = 1'b0;
        #2;
        check("rst_valid", stage_valid_o, 0);
        check("rst_occ", occupancy_o, 0);
        check("rst_drop", drop_cnt_o, 0);
        tick();

        // Mixed traffic pattern, checked against the model.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            token_valid_i  = (i % 3 != 0);
            token_i        = 32'h1000 + W'(i);
            stall_i        = (i % 7 == 3);
            retire_ready_i = (i % 5 != 2) && (i < 20 || i > 30);
            clear_stage_i  = (i % 6 == 4) ? 4'b0010 : ((i % 11 == 8) ? 4'b1001 : 4'b0000);
            tick();
        end
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rm_token_chain.md
RM_TOKEN_CHAIN -- requirements
Module: rm_token_chain

Interface
REQ-001 Parameter NUM_STAGES, default 4: pipeline depth, legal range 2..16.
REQ-002 Parameter TOKEN_W, default 32: monitor control token width.
REQ-003 clk_i  in  1  sole clock; all state on rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 token_valid_i  in  1  upstream token offered.
REQ-006 token_i  in  TOKEN_W  upstream token.
REQ-007 token_ready_o  out  1  chain accepts token this cycle.
REQ-008 stall_i  in  1  freeze whole chain.
REQ-009 clear_stage_i  in  NUM_STAGES  per-stage invalidate, bit k targets stage k.
REQ-010 stage_valid_o  out  NUM_STAGES  per-stage occupancy.
REQ-011 stage_token_o  out  NUM_STAGES*TOKEN_W  flattened stage tokens, stage k at bits [k*TOKEN_W +: TOKEN_W].
REQ-012 retire_valid_o  out  1  tail token available.
REQ-013 retire_token_o  out  TOKEN_W  tail token.
REQ-014 retire_ready_i  in  1  downstream accepts tail token.
REQ-015 occupancy_o  out  $clog2(NUM_STAGES+1)  count of valid stages.
REQ-016 drop_cnt_o  out  16  saturating count of tokens removed by clear.

Function
REQ-017 Define live[k] = stage_valid[k] & ~clear_stage_i[k].
REQ-018 retire_valid_o SHALL equal live[NUM_STAGES-1]; retire_token_o SHALL equal stage token NUM_STAGES-1.
REQ-019 advance = ~stall_i & (~live[NUM_STAGES-1] | retire_ready_i); token_ready_o SHALL equal advance & ~rst_i.
REQ-020 On advance: stage k+1 <= {live[k], token[k]}; stage 0 <= {token_valid_i, token_i}; tail retires iff live[NUM_STAGES-1] & retire_ready_i.
REQ-021 Without advance: every stage holds its token; valid[k] <= live[k].
REQ-022 Clear has priority over retire and shift; a cleared token is never retired nor forwarded; the vacated slot moves as a bubble.
REQ-023 Latency: token accepted in cycle c, no stall, retire_ready_i=1 -> retire_valid_o in cycle c+NUM_STAGES; each stall cycle adds one.
REQ-024 Order SHALL be preserved; no duplication, no loss except by clear.
REQ-025 occupancy_o SHALL equal popcount(stage_valid_o) every cycle.
REQ-026 drop_cnt_o SHALL add popcount(stage_valid & clear_stage_i) per cycle, saturating at 0xFFFF.
REQ-027 Full: all stages valid, tail not retired -> token_ready_o=0, no token lost.
REQ-028 Invalid-stage token contents are don't-care but SHALL NOT be X after reset.

Reset
REQ-029 rst_i=1 at a rising edge SHALL clear all stage valids, stage tokens to 0, drop_cnt_o to 0; reset overrides stall, clear and handshakes.
REQ-030 During reset: token_ready_o=0, retire_valid_o=0 from the following cycle, occupancy_o=0.

Configuration
REQ-031 Macro RM_TOKEN_CHAIN_BYPASS_EN defined: when all stages invalid, stall_i=0, token_valid_i=1 and retire_ready_i=1, token SHALL pass combinationally to retire_token_o/retire_valid_o same cycle and SHALL NOT enter stage 0.
REQ-032 Macro undefined: no bypass; latency exactly per REQ-023 always.

Verification (NUM_STAGES=4, TOKEN_W=32)
REQ-033 Reset, push 0x000000A5 cycle 0, retire_ready_i=1 -> retire_valid_o=1 with 0xA5 in cycle 4 only; occupancy_o=1 cycles 1-4 (bypass off); with bypass on -> retire in cycle 0, occupancy stays 0.
REQ-034 retire_ready_i=0, push 1,2,3,4 cycles 0-3 -> cycle 4 stage_valid_o=4'b1111, occupancy_o=4, token_ready_o=0; raise ready -> retires 1,2,3,4 in consecutive cycles.
REQ-035 Chain full 1..4, clear_stage_i=4'b0100 one cycle -> token 2 dropped, drop_cnt_o=1, occupancy_o=3, retire order 1,3,4.
REQ-036 Token in flight, stall_i=1 three cycles -> stage_token_o frozen, token_ready_o=0, retire delayed exactly 3 cycles.
REQ-037 Tail valid, retire_ready_i=1, clear_stage_i[3]=1 same cycle -> retire_valid_o=0, no retire, drop_cnt_o increments by 1.
REQ-038 Three tokens in flight, rst_i=1 one cycle -> next cycle stage_valid_o=0, occupancy_o=0, drop_cnt_o=0.
